instr_sequencer: RTL and testbench

- Upstream stage of control_matrix: fetches instruction words, latches opcode and register-select fields, drives the 2-bit `state` phase that control_matrix decodes.
- Runs FETCH(0) -> DECODE(1) -> EXECUTE(2) -> WRITEBACK(3), with a fetch handshake, a global stall, a HALT opcode trap and a retired-instruction counter.

---
 rtl/instr_sequencer.sv | 88 ++++++++
 tb/tb_instr_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: FETCH/DECODE/EXECUTE/WRITEBACK phase sequencer with stall, HALT trap and retire counter.
// Define SEQ_STEP_EN to gate each fetch behind a single-step pulse.
module instr_sequencer #(
    parameter int         INSTR_W     = 16,
    parameter int         COUNT_W     = 16,
    parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
    input  logic               clock,
    input  logic               state_machine_reset,
    input  logic [INSTR_W-1:0] instr_word,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic               resume,
    input  logic               step,
    output logic [1:0]         state,
    output logic [3:0]         opcode,
    output logic [4:0]         alternate_read,
    output logic [4:0]         alt_write,
    output logic               fetch_ack,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;
    state_t             r_state, w_next, w_adv;
    logic [3:0]         r_opcode;
    logic [4:0]         r_alt_read, r_alt_write;
    logic [COUNT_W-1:0] r_count;
    logic               w_permit;
    logic               w_unused;

    assign w_unused = ^{instr_word, step};

`ifdef SEQ_STEP_EN
    logic r_step_armed;
    assign w_permit = r_step_armed | step;
    always_ff @(posedge clock or negedge state_machine_reset) begin
        if (!state_machine_reset)
            r_step_armed <= 1'b0;
        else if (fetch_ack)
            r_step_armed <= 1'b0;
        else if (step && !stall)
            r_step_armed <= 1'b1;
    end
`else
    assign w_permit = 1'b1;
`endif

    assign fetch_ack      = (r_state == S_FETCH) && instr_valid && !stall && w_permit;
    assign state          = (r_state == S_HALT) ? 2'd0 : r_state[1:0];
    assign halted         = (r_state == S_HALT);
    assign opcode         = r_opcode;
    assign alternate_read = r_alt_read;
    assign alt_write      = r_alt_write;
    assign instr_count    = r_count;

    always_comb begin
        w_adv = S_FETCH;
        case (r_state)
            S_FETCH:     w_adv = fetch_ack ? S_DECODE : S_FETCH;
            S_DECODE:    w_adv = (r_opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   w_adv = S_WRITEBACK;
            S_WRITEBACK: w_adv = S_FETCH;
            S_HALT:      w_adv = resume ? S_FETCH : S_HALT;
            default:     w_adv = S_FETCH;
        endcase
        // HALT only listens to resume, so stall cannot pin it
        w_next = (stall && r_state != S_HALT) ? r_state : w_adv;
    end

    always_ff @(posedge clock or negedge state_machine_reset) begin
        if (!state_machine_reset) begin
            r_state     <= S_FETCH;
            r_opcode    <= 4'd0;
            r_alt_read  <= 5'd0;
            r_alt_write <= 5'd0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (fetch_ack) begin
                r_opcode    <= instr_word[INSTR_W-1 -: 4];
                r_alt_read  <= instr_word[INSTR_W-5 -: 5];
                r_alt_write <= instr_word[INSTR_W-10 -: 5];
            end
            if (r_state == S_WRITEBACK && !stall && r_count != '1)
                r_count <= r_count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of phase sequencing, field latch, stall, HALT/resume, saturation and reset.
module tb_instr_sequencer;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr_word = 16'h0000;
    logic        instr_valid = 1'b0, stall = 1'b0, resume = 1'b0, step = 1'b0;
    logic [1:0]  state, state_s;
    logic [3:0]  opcode, opcode_s;
    logic [4:0]  alt_read, alt_write, alt_read_s, alt_write_s;
    logic        fetch_ack, halted, fetch_ack_s, halted_s;
    logic [15:0] count;
    logic [1:0]  count_s;
    int          n_checks = 0, n_pass = 0;

    always #5 clock = ~clock;

    instr_sequencer dut (
        .clock(clock), .state_machine_reset(rst_n), .instr_word(instr_word),
        .instr_valid(instr_valid), .stall(stall), .resume(resume), .step(step),
        .state(state), .opcode(opcode), .alternate_read(alt_read), .alt_write(alt_write),
        .fetch_ack(fetch_ack), .halted(halted), .instr_count(count)
    );

    instr_sequencer #(.COUNT_W(2)) dut_sat (
        .clock(clock), .state_machine_reset(rst_n), .instr_word(instr_word),
        .instr_valid(instr_valid), .stall(stall), .resume(resume), .step(step),
        .state(state_s), .opcode(opcode_s), .alternate_read(alt_read_s), .alt_write(alt_write_s),
        .fetch_ack(fetch_ack_s), .halted(halted_s), .instr_count(count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #1;
        check("rst_state", state, 0);
        check("rst_opcode", opcode, 0);
        check("rst_halted", halted, 0);
        check("rst_count", count, 0);
        tick(2);
        rst_n       = 1'b1;
        step        = 1'b1;
        instr_word  = 16'h1000;
        instr_valid = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("seq_state%0d", i), state, i % 4);
            check($sformatf("seq_ack%0d", i), fetch_ack, (i % 4) == 0);
            tick();
        end
        check("seq_count", count, 3);
        check("seq_opcode", opcode, 4'h1);

        instr_word = 16'h2A5C;
        tick();
        instr_word = 16'h1000;
        check("fld_state1", state, 1);
        check("fld_opcode1", opcode, 4'h2);
        check("fld_ar1", alt_read, 5'b10100);
        check("fld_aw1", alt_write, 5'b10111);
        tick();
        check("fld_state2", state, 2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_state%0d", i), state, 2);
        end
        stall = 1'b0;
        tick();
        check("post_stall_state", state, 3);
        check("fld_opcode3", opcode, 4'h2);
        check("fld_aw3", alt_write, 5'b10111);
        check("count_before_wb", count, 3);
        tick();
        check("post_wb_state", state, 0);
        check("post_wb_count", count, 4);

        stall = 1'b1;
        #1;
        check("stall_fetch_ack", fetch_ack, 0);
        tick();
        check("stall_fetch_state", state, 0);
        stall = 1'b0;
        instr_word = 16'hF000;
        #1;
        check("unstall_ack", fetch_ack, 1);

        tick();
        check("halt_decode_state", state, 1);
        check("halt_decode_halted", halted, 0);
        tick();
        check("halt_halted", halted, 1);
        check("halt_state", state, 0);
        check("halt_opcode", opcode, 4'hF);
        check("halt_ack", fetch_ack, 0);
        tick(3);
        check("halt_hold", halted, 1);
        check("halt_count", count, 4);
        stall  = 1'b1;
        resume = 1'b1;
        tick();
        stall  = 1'b0;
        resume = 1'b0;
        instr_word = 16'h1000;
        check("resume_halted", halted, 0);
        check("resume_state", state, 0);
        #1;
        check("resume_ack", fetch_ack, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_ignored_state", state, 1);
        tick(7);
        check("after_resume_count", count, 6);
        check("sat_count", count_s, 2'b11);

        tick();
        check("mid_state", state, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_opcode", opcode, 0);
        tick();
`ifdef SEQ_STEP_EN
        step  = 1'b0;
        rst_n = 1'b1;
        #1;
        check("step_none_ack", fetch_ack, 0);
        tick(3);
        check("step_none_state", state, 0);
        instr_valid = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        instr_valid = 1'b1;
        #1;
        check("step_armed_ack", fetch_ack, 1);
        tick(4);
        check("step_one_count", count, 1);
        check("step_disarmed_ack", fetch_ack, 0);
        tick(3);
        check("step_wait_state", state, 0);
        check("step_wait_count", count, 1);
`else
        rst_n = 1'b1;
        tick(4);
        check("rerun_count", count, 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
